// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  // Priority pointer: which requester wins the next contended cycle.
  typedef enum logic {
    WB_EX  = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  localparam reg_addr_t REG_X0     = {REG_ADDR_W{1'b0}};
  localparam xword_t    XWORD_ZERO = {XLEN{1'b0}};

  // x0 is hardwired zero: never tracked, never written, never a hazard.
  function automatic logic is_x0(input reg_addr_t addr);
    return addr == REG_X0;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-requester round-robin arbiter (EX vs MEM) with a registered
// priority bit. Readiness of one side depends only on the other side's
// request and the priority bit, never on its own request.
module wb_rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_ex_i,
  input  logic req_mem_i,
  output logic ready_ex_o,
  output logic ready_mem_o,
  output logic grant_ex_o,
  output logic grant_mem_o
);

  wb_src_e prio_q;
  wb_src_e prio_d;

  // Readiness, grants, and priority hand-over after a contended cycle.
  always_comb begin
    ready_ex_o  = !req_mem_i || (prio_q == WB_EX);
    ready_mem_o = !req_ex_i  || (prio_q == WB_MEM);
    grant_ex_o  = req_ex_i  && ready_ex_o;
    grant_mem_o = req_mem_i && ready_mem_o;
    prio_d      = prio_q;
    if (req_ex_i && req_mem_i) begin
      if (grant_ex_o) begin
        prio_d = WB_MEM;
      end else begin
        prio_d = WB_EX;
      end
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority register; EX wins the first contention after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= WB_EX;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: shares the single write port between
// EX and MEM, tracks in-flight destinations in a pending scoreboard and
// reports read-operand hazards to decode.
// Optional feature: define REGFILE_FWD_EN to forward the value sitting in
// the output stage to decode instead of stalling on it.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic      phi2,
  input  logic      rst_n,
  input  logic      iss_valid,
  input  reg_addr_t iss_rd,
  output logic      iss_ready,
  input  logic      ex_valid,
  input  reg_addr_t ex_rd,
  input  xword_t    ex_value,
  output logic      ex_ready,
  input  logic      mem_valid,
  input  reg_addr_t mem_rd,
  input  xword_t    mem_value,
  output logic      mem_ready,
  output reg_addr_t reg_wb_addr,
  output xword_t    reg_wb_value,
  input  reg_addr_t rd_addrs  [0:1],
  output logic      rd_hazard [0:1],
  output logic      fwd_valid [0:1],
  output xword_t    fwd_value [0:1]
);

  logic                ex_grant_s;
  logic                mem_grant_s;
  logic                claim_s;
  reg_addr_t           wb_addr_q;
  reg_addr_t           wb_addr_d;
  xword_t              wb_value_q;
  xword_t              wb_value_d;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  wb_rr_arbiter2 u_arb (
    .clk_i       (phi2),
    .rst_ni      (rst_n),
    .req_ex_i    (ex_valid),
    .req_mem_i   (mem_valid),
    .ready_ex_o  (ex_ready),
    .ready_mem_o (mem_ready),
    .grant_ex_o  (ex_grant_s),
    .grant_mem_o (mem_grant_s)
  );

  assign reg_wb_addr  = wb_addr_q;
  assign reg_wb_value = wb_value_q;

  // Claim acceptance: pending is sampled before this edge's clear, so a
  // claim that collides with the retiring register is refused.
  always_comb begin
    iss_ready = is_x0(iss_rd) || !pending_q[iss_rd];
    claim_s   = iss_valid && iss_ready && !is_x0(iss_rd);
  end

  // Scoreboard next state: retire the output-stage register, then record a new claim.
  always_comb begin
    pending_d = pending_q;
    if (!is_x0(wb_addr_q)) begin
      pending_d[wb_addr_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (claim_s) begin
      pending_d[iss_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
  end

  // Output stage next state: load the granted request, else idle with value held.
  always_comb begin
    wb_addr_d  = REG_X0;
    wb_value_d = wb_value_q;
    if (ex_grant_s) begin
      wb_addr_d  = ex_rd;
      wb_value_d = ex_value;
    end else if (mem_grant_s) begin
      wb_addr_d  = mem_rd;
      wb_value_d = mem_value;
    end else begin
      wb_addr_d  = REG_X0;
      wb_value_d = wb_value_q;
    end
  end

  // State registers; reset drops the in-flight write and all claims.
  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr_q  <= REG_X0;
      wb_value_q <= XWORD_ZERO;
      pending_q  <= {NUM_REGS{1'b0}};
    end else begin
      wb_addr_q  <= wb_addr_d;
      wb_value_q <= wb_value_d;
      pending_q  <= pending_d;
    end
  end

  // Decode read-port hazards, optionally bypassing the output-stage value.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_hazard[i] = 1'b0;
      fwd_valid[i] = 1'b0;
      fwd_value[i] = XWORD_ZERO;
`ifdef REGFILE_FWD_EN
      if (!is_x0(rd_addrs[i]) && (rd_addrs[i] == wb_addr_q)) begin
        fwd_valid[i] = 1'b1;
        fwd_value[i] = wb_value_q;
        rd_hazard[i] = 1'b0;
      end else begin
        rd_hazard[i] = !is_x0(rd_addrs[i]) && pending_q[rd_addrs[i]];
      end
`else
      rd_hazard[i] = !is_x0(rd_addrs[i]) && pending_q[rd_addrs[i]];
`endif
    end
  end

endmodule
